// File: rtl/util_pkg.sv
// util_pkg: definitions shared by the util_* library blocks.
//   deb_state_t  - debouncer state encoding (LOW / CHK_H / HIGH / CHK_L)
//   EDGE_*       - accepted values of the debouncer C_EDGE_TYPE parameter
package util_pkg;

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_CHK_H = 2'd1,
        ST_HIGH  = 2'd2,
        ST_CHK_L = 2'd3
    } deb_state_t;

    localparam string EDGE_RISE = "rise";
    localparam string EDGE_FALL = "fall";
    localparam string EDGE_BOTH = "both";

endpackage

// File: rtl/util_sat_counter.sv
// util_sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock
//   rst   - asynchronous reset, active-high (count -> 0)
//   en    - increment request (ignored once saturated)
//   clr   - synchronous clear, has priority over en
//   count - current count, WIDTH bits
module util_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/util_debounce.sv
// util_debounce: glitch filter for an already-synchronized level. The output
// level follows din only after din has held a new value for DEBOUNCE_CYCLE
// consecutive clocks; one-cycle rise/fall pulses mark each accepted change.
// Optional feature macro: UTIL_DEBOUNCE_GLITCH_CNT_EN builds the saturating
// rejected-change counter; without it glitch_cnt is tied to zero.
// Ports:
//   clk        - clock
//   rst        - asynchronous reset, active-high
//   din        - synchronized input level (clk domain)
//   dout       - debounced level
//   dout_r     - one-cycle pulse on dout 0->1 (if enabled by C_EDGE_TYPE)
//   dout_f     - one-cycle pulse on dout 1->0 (if enabled by C_EDGE_TYPE)
//   busy       - high while a candidate change is being qualified
//   glitch_cnt - number of rejected candidate changes, saturating
module util_debounce
    import util_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLE   = 16,
    parameter string       C_EDGE_TYPE      = "both",
    parameter logic        INIT_LEVEL       = 1'b0,
    parameter int unsigned GLITCH_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        din,
    output logic                        dout,
    output logic                        dout_r,
    output logic                        dout_f,
    output logic                        busy,
    output logic [GLITCH_CNT_WIDTH-1:0] glitch_cnt
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLE - 1);
    localparam deb_state_t       ST_RST   = INIT_LEVEL ? ST_HIGH : ST_LOW;

    // Any string other than "fall"/"rise" enables both pulses.
    localparam logic RISE_EN = (C_EDGE_TYPE != EDGE_FALL);
    localparam logic FALL_EN = (C_EDGE_TYPE != EDGE_RISE);
    localparam logic BYPASS  = (DEBOUNCE_CYCLE == 1);

    deb_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             dout_next, dout_r_next, dout_f_next, busy_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RST;
            cnt    <= '0;
            dout   <= INIT_LEVEL;
            dout_r <= 1'b0;
            dout_f <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            dout   <= dout_next;
            dout_r <= dout_r_next;
            dout_f <= dout_f_next;
            busy   <= busy_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        dout_next   = dout;
        dout_r_next = 1'b0;
        dout_f_next = 1'b0;

        case (state)
            ST_LOW: begin
                if (din) begin
                    if (BYPASS) begin
                        state_next  = ST_HIGH;
                        dout_next   = 1'b1;
                        dout_r_next = RISE_EN;
                        cnt_next    = '0;
                    end else begin
                        // First sample of the new level counts as one.
                        state_next = ST_CHK_H;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            ST_CHK_H: begin
                if (!din) begin
                    state_next = ST_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next  = ST_HIGH;
                    dout_next   = 1'b1;
                    dout_r_next = RISE_EN;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!din) begin
                    if (BYPASS) begin
                        state_next  = ST_LOW;
                        dout_next   = 1'b0;
                        dout_f_next = FALL_EN;
                        cnt_next    = '0;
                    end else begin
                        state_next = ST_CHK_L;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            ST_CHK_L: begin
                if (din) begin
                    state_next = ST_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next  = ST_LOW;
                    dout_next   = 1'b0;
                    dout_f_next = FALL_EN;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_RST;
                cnt_next   = '0;
            end
        endcase

        // Registered copy of the next state's CHK decode, so busy lines up
        // with the state register.
        busy_next = (state_next == ST_CHK_H) || (state_next == ST_CHK_L);
    end

`ifdef UTIL_DEBOUNCE_GLITCH_CNT_EN
    logic glitch;

    // A glitch is din falling back to the stable level during qualification.
    assign glitch = ((state == ST_CHK_H) && !din) || ((state == ST_CHK_L) && din);

    util_sat_counter #(
        .WIDTH(GLITCH_CNT_WIDTH)
    ) u_glitch_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (glitch),
        .clr  (1'b0),
        .count(glitch_cnt)
    );
`else
    assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_util_debounce.sv
module tb_util_debounce;

`ifdef UTIL_DEBOUNCE_GLITCH_CNT_EN
    localparam bit GEN = 1'b1;
`else
    localparam bit GEN = 1'b0;
`endif

    // Four DUTs share one stimulus stream:
    //   0: DEBOUNCE_CYCLE=16, both edges
    //   1: DEBOUNCE_CYCLE=16, rise only
    //   2: DEBOUNCE_CYCLE=1,  both edges
    //   3: DEBOUNCE_CYCLE=16, unknown edge string (acts as both), 2-bit glitch_cnt
    localparam int DEB  [4] = '{16, 16, 1, 16};
    localparam int RISE [4] = '{1, 1, 1, 1};
    localparam int FALL [4] = '{1, 0, 1, 1};
    localparam int GMAX [4] = '{65535, 65535, 65535, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic [3:0]  dout, dr, df, busy;
    logic [15:0] g0, g1, g2;
    logic [1:0]  g3;

    always #5 clk = ~clk;

    util_debounce #(.DEBOUNCE_CYCLE(16), .C_EDGE_TYPE("both"), .INIT_LEVEL(1'b0), .GLITCH_CNT_WIDTH(16)) u_d0 (
        .clk(clk), .rst(rst), .din(din), .dout(dout[0]), .dout_r(dr[0]), .dout_f(df[0]), .busy(busy[0]), .glitch_cnt(g0));
    util_debounce #(.DEBOUNCE_CYCLE(16), .C_EDGE_TYPE("rise"), .INIT_LEVEL(1'b0), .GLITCH_CNT_WIDTH(16)) u_d1 (
        .clk(clk), .rst(rst), .din(din), .dout(dout[1]), .dout_r(dr[1]), .dout_f(df[1]), .busy(busy[1]), .glitch_cnt(g1));
    util_debounce #(.DEBOUNCE_CYCLE(1), .C_EDGE_TYPE("both"), .INIT_LEVEL(1'b0), .GLITCH_CNT_WIDTH(16)) u_d2 (
        .clk(clk), .rst(rst), .din(din), .dout(dout[2]), .dout_r(dr[2]), .dout_f(df[2]), .busy(busy[2]), .glitch_cnt(g2));
    util_debounce #(.DEBOUNCE_CYCLE(16), .C_EDGE_TYPE("bogus"), .INIT_LEVEL(1'b0), .GLITCH_CNT_WIDTH(2)) u_d3 (
        .clk(clk), .rst(rst), .din(din), .dout(dout[3]), .dout_r(dr[3]), .dout_f(df[3]), .busy(busy[3]), .glitch_cnt(g3));

    typedef struct packed {
        logic        dout;
        logic        dr;
        logic        df;
        logic        busy;
        logic [15:0] g;
    } obs_t;
    typedef obs_t [3:0] obs4_t;

    obs4_t sb[$];

    // Reference model: stable level plus length of the current run of
    // samples that disagree with it.
    int   m_lvl [4];
    int   m_run [4];
    int   m_g   [4];
    logic m_dr  [4];
    logic m_df  [4];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_lvl[i] = 0;
            m_run[i] = 0;
            m_g[i]   = 0;
            m_dr[i]  = 1'b0;
            m_df[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic d);
        for (int i = 0; i < 4; i++) begin
            m_dr[i] = 1'b0;
            m_df[i] = 1'b0;
            if (int'(d) != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] >= DEB[i]) begin
                    m_lvl[i] = int'(d);
                    if (d) m_dr[i] = (RISE[i] != 0);
                    else   m_df[i] = (FALL[i] != 0);
                    m_run[i] = 0;
                end
            end else begin
                if (m_run[i] > 0 && GEN && m_g[i] < GMAX[i]) m_g[i]++;
                m_run[i] = 0;
            end
        end
    endtask

    task automatic push_expect();
        obs4_t e;
        for (int i = 0; i < 4; i++) begin
            e[i].dout = m_lvl[i][0];
            e[i].dr   = m_dr[i];
            e[i].df   = m_df[i];
            e[i].busy = (m_run[i] > 0);
            e[i].g    = 16'(m_g[i]);
        end
        sb.push_back(e);
    endtask

    task automatic compare_out();
        obs4_t e;
        logic [15:0] g;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       g = g0;
                1:       g = g1;
                2:       g = g2;
                default: g = {14'd0, g3};
            endcase
            check_val($sformatf("d%0d_dout", i), 32'(dout[i]), 32'(e[i].dout));
            check_val($sformatf("d%0d_rise", i), 32'(dr[i]), 32'(e[i].dr));
            check_val($sformatf("d%0d_fall", i), 32'(df[i]), 32'(e[i].df));
            check_val($sformatf("d%0d_busy", i), 32'(busy[i]), 32'(e[i].busy));
            check_val($sformatf("d%0d_gcnt", i), 32'(g), 32'(e[i].g));
        end
    endtask

    // Called at a negedge; drives inputs, predicts, samples 1 after posedge.
    task automatic step(input logic d, input logic r);
        din = d;
        rst = r;
        if (r) model_reset();
        else   model_step(d);
        push_expect();
        @(posedge clk);
        #1;
        compare_out();
        @(negedge clk);
    endtask

    int n_busy;
    int rise_at;
    int found;

    initial begin
        model_reset();
        @(negedge clk);

        // Reset held, then released with din low.
        for (int k = 0; k < 30; k++) step(1'b0, 1'b1);
        for (int k = 0; k < 50; k++) step(1'b0, 1'b0);

        // Full rise qualification.
        n_busy  = 0;
        rise_at = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0);
            if (busy[0]) n_busy++;
            if (dr[0] && rise_at == 0) rise_at = k;
        end
        check_val("busy_len", 32'(n_busy), 32'd15);
        check_val("rise_edge", 32'(rise_at), 32'd16);

        // Full fall qualification (rise-only DUT must not pulse dout_f).
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0);

        // Short high excursion rejected.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
        check_val("g_single", 32'(g0), GEN ? 32'd1 : 32'd0);

        // Back to HIGH, then din toggles every cycle.
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 100; k++) step((k % 2) != 0, 1'b0);
        check_val("toggle_hold", 32'(dout[0]), 32'd1);
        check_val("g_toggle", 32'(g0), GEN ? 32'd51 : 32'd0);

        // Reset in the middle of a rise qualification.
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        push_expect();
        compare_out();
        check_val("rst_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1);

        found = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, 1'b0);
            if (dout[0]) begin
                found = k;
                break;
            end
        end
        check_val("relatch", 32'(found), 32'd16);

        // Five glitches from LOW; 2-bit counter sticks at 3.
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        check_val("g_sat", 32'(g3), GEN ? 32'd3 : 32'd0);
        check_val("g_post_rst", 32'(g0), GEN ? 32'd5 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/util_debounce.md
Name: util_debounce

Overview:
- Glitch filter that sits directly downstream of util_metastable.
- Consumes the already-synchronized level (util_metastable dout) and publishes a filtered level.
- The filtered level changes only after the input has held a new value for DEBOUNCE_CYCLE consecutive clocks.
- Produces one-cycle rise/fall event pulses on the filtered level, for use by switch, button and slow-sensor consumers.

Parameters:
- DEBOUNCE_CYCLE, 16: consecutive equal samples required to accept a level change; legal range 1..65535.
- C_EDGE_TYPE, "both": which event pulses are enabled: "rise", "fall" or "both"; a disabled pulse output is tied 0.
- INIT_LEVEL, 1'b0: value of dout and the stable level on reset.
- GLITCH_CNT_WIDTH, 16: width of glitch_cnt.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- din  input  1  synchronized level; must already be in the clk domain.
- dout  output  1  debounced level.
- dout_r  output  1  one-cycle pulse when dout goes 0->1.
- dout_f  output  1  one-cycle pulse when dout goes 1->0.
- busy  output  1  high while a candidate change is being qualified.
- glitch_cnt  output  GLITCH_CNT_WIDTH  count of rejected changes (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - state = INIT_LEVEL ? ST_HIGH : ST_LOW.
  - cnt = 0, dout = INIT_LEVEL.
  - dout_r = dout_f = busy = 0, glitch_cnt = 0.
- No pulse is generated on reset release.
- State machine, all transitions on rising clk:
  - ST_LOW: din=1 -> ST_CHK_H, cnt=1. Otherwise stay.
  - ST_CHK_H:
    - din=0 -> ST_LOW, cnt=0, glitch event.
    - din=1 and cnt==DEBOUNCE_CYCLE-1 -> ST_HIGH, dout<=1, dout_r<=1 (if enabled), cnt=0.
    - Otherwise cnt++.
  - ST_HIGH and ST_CHK_L: mirror images of the above with polarities swapped; the accept case asserts dout_f.
- DEBOUNCE_CYCLE==1: the CHK states are bypassed. ST_LOW with din=1 goes straight to ST_HIGH, so dout equals din delayed one register, and busy stays 0.
- Latency: dout changes on the DEBOUNCE_CYCLE-th consecutive rising edge that samples the new din value. All outputs are registered.
- Pulses:
  - dout_r and dout_f are high for exactly one cycle, coincident with the dout transition.
  - They are never both high.
  - They deassert on the next cycle regardless of din.
- busy = 1 exactly in ST_CHK_H and ST_CHK_L (registered, state-decoded).
- cnt width = $clog2(DEBOUNCE_CYCLE+1). cnt never exceeds DEBOUNCE_CYCLE-1.
- A glitch occurs when din returns to the stable level while in a CHK state:
  - cnt clears and dout is unchanged.
  - glitch_cnt increments and saturates at all-ones; it never wraps.
- din toggling every cycle: dout never changes, and glitch_cnt increments on each return.
- Reset asserted mid-qualification: all of the reset values above apply immediately, and a partially qualified change is discarded.
- Illegal C_EDGE_TYPE string: treated as "both".

Optional Feature:
- Macro: UTIL_DEBOUNCE_GLITCH_CNT_EN.
- Defined: the glitch_cnt register and its saturating increment are built as described above.
- Undefined: no counter logic is generated, and glitch_cnt is tied to 0. The port list is unchanged so instantiations stay identical.

Decomposition:
- Shared package util_pkg: state encoding localparams (ST_LOW=2'd0, ST_CHK_H=2'd1, ST_HIGH=2'd2, ST_CHK_L=2'd3) and the edge-type string constants.
- Sub-module util_sat_counter (enable, clear, saturating increment, WIDTH parameter):
  - Used for glitch_cnt.
  - Reusable elsewhere in the library.
- The qualification counter stays inline.

Test Plan:
1. Reset with INIT_LEVEL=0 for 30 cycles; release; din held 0 for 50 cycles -> dout=0, no pulses, busy=0, glitch_cnt=0.
2. DEBOUNCE_CYCLE=16, din 0->1 held -> busy high for 15 cycles; dout=1 and dout_r=1 on the 16th sampling edge; dout_r low on the next cycle.
3. din high for 5 cycles then back to 0 -> dout stays 0, busy drops, glitch_cnt=1 (macro on) or 0 (macro off).
4. din alternating every cycle for 100 cycles from ST_HIGH -> dout stays 1, no pulses, glitch_cnt=50.
5. C_EDGE_TYPE="rise", full 1->0 qualification -> dout falls after 16 edges, dout_f stays 0.
6. rst pulsed at cnt=10 during ST_CHK_H -> immediate dout=INIT_LEVEL, busy=0, cnt=0; after release, din=1 again requires the full 16 cycles. Also run DEBOUNCE_CYCLE=1 -> dout follows din with a 1-cycle delay. Also run GLITCH_CNT_WIDTH=2 with 5 glitches -> glitch_cnt saturates at 3.
